// File: rtl/iobuf_bank_turnaround.sv
// iobuf_bank_turnaround: registered bidirectional pad bank with dead-cycle bus turnaround.
module iobuf_bank_turnaround #(
  parameter int WIDTH = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic             GTS,
  input  logic             T,
  input  logic [WIDTH-1:0] I,
  inout  wire  [WIDTH-1:0] IO,
  output logic [WIDTH-1:0] O,
  output logic             O_VALID,
  output logic             DRIVE,
  output logic             BUSY
);
  localparam int CW = (TURN_CYCLES < 2) ? 1 : $clog2(TURN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = (TURN_CYCLES == 0) ? '0 : CW'(TURN_CYCLES - 1);
  typedef enum logic [1:0] {RX, TURN_TX, TX, TURN_RX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] oq_q, oq_d, o_q, o_d;
  logic o_valid_q, o_valid_d;
  logic tx_req;
  always_comb begin
    tx_req = 1'b0;
    if (!T && !GTS) tx_req = 1'b1;
    DRIVE = 1'b0;
    if (state_q == TX && !GTS) DRIVE = 1'b1;
  end
  assign BUSY = (state_q == TURN_TX) || (state_q == TURN_RX);
  assign IO = DRIVE ? oq_q : {WIDTH{1'bz}};
  assign O = o_q;
  assign O_VALID = o_valid_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    oq_d = I;
    o_d = (state_q == RX) ? IO : o_q;
    o_valid_d = (state_q == RX);
    // An unknown T/GTS leaves tx_req low, so it always resolves toward receive.
    case (state_q)
      RX: if (tx_req) begin
        state_d = (TURN_CYCLES == 0) ? TX : TURN_TX;
        cnt_d = CNT_INIT;
      end
      TURN_TX: if (!tx_req) state_d = RX;
        else if (cnt_q == '0) state_d = TX;
        else cnt_d = cnt_q - 1'b1;
      TX: if (!tx_req) begin
        state_d = (TURN_CYCLES == 0) ? RX : TURN_RX;
        cnt_d = CNT_INIT;
      end
      default: if (cnt_q == '0) state_d = RX;
        else cnt_d = cnt_q - 1'b1;
    endcase
  end
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= RX;
      cnt_q <= '0;
      oq_q <= '0;
      o_q <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      oq_q <= oq_d;
      o_q <= o_d;
      o_valid_q <= o_valid_d;
    end
  end
endmodule

// File: tb/tb_iobuf_bank_turnaround.sv
// tb_iobuf_bank_turnaround: directed checks of turnaround timing, GTS and async reset.
module tb_iobuf_bank_turnaround;
  logic C, CLR_N, GTS, T, clr0_n, t0, ext_en;
  logic [7:0] I, i0, ext;
  wire [7:0] io_w, io0_w;
  logic [7:0] o, o0;
  logic o_valid, drive, busy, o_valid0, drive0, busy0;
  int passed = 0;
  int total = 0;
  // Pull-ups make an undriven pad read as 8'hFF.
  for (genvar k = 0; k < 8; k++) begin : g_pu
    pullup (io_w[k]);
    pullup (io0_w[k]);
  end
  assign io_w = ext_en ? ext : 8'hzz;
  iobuf_bank_turnaround #(.WIDTH(8), .TURN_CYCLES(2)) dut (
    .C(C), .CLR_N(CLR_N), .GTS(GTS), .T(T), .I(I), .IO(io_w),
    .O(o), .O_VALID(o_valid), .DRIVE(drive), .BUSY(busy)
  );
  iobuf_bank_turnaround #(.WIDTH(8), .TURN_CYCLES(0)) dut0 (
    .C(C), .CLR_N(clr0_n), .GTS(GTS), .T(t0), .I(i0), .IO(io0_w),
    .O(o0), .O_VALID(o_valid0), .DRIVE(drive0), .BUSY(busy0)
  );
  always #5 C = ~C;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge C);
    #1;
  endtask
  initial begin
    C = 0; CLR_N = 1; clr0_n = 1; GTS = 0; T = 1; t0 = 1;
    I = 8'h00; i0 = 8'h00; ext = 8'hA5; ext_en = 1;
    #1 CLR_N = 0; clr0_n = 0;
    #1;
    chk("rst_o", o, 8'h00);
    chk("rst_ovalid", {7'd0, o_valid}, 8'd0);
    chk("rst_drive", {7'd0, drive}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_o0", o0, 8'h00);
    #10 CLR_N = 1; clr0_n = 1;
    tick();
    chk("idle_o", o, 8'hA5);
    chk("idle_ovalid", {7'd0, o_valid}, 8'd1);
    chk("idle_drive", {7'd0, drive}, 8'd0);
    chk("idle_busy", {7'd0, busy}, 8'd0);
    T = 0; I = 8'h3C;
    tick();
    chk("ttx0_busy", {7'd0, busy}, 8'd1);
    chk("ttx0_drive", {7'd0, drive}, 8'd0);
    chk("ttx0_o", o, 8'hA5);
    ext_en = 0;
    #1 chk("ttx0_io", io_w, 8'hFF);
    tick();
    chk("ttx1_busy", {7'd0, busy}, 8'd1);
    chk("ttx1_io", io_w, 8'hFF);
    chk("ttx1_ovalid", {7'd0, o_valid}, 8'd0);
    chk("ttx1_o", o, 8'hA5);
    tick();
    chk("tx_busy", {7'd0, busy}, 8'd0);
    chk("tx_drive", {7'd0, drive}, 8'd1);
    chk("tx_io", io_w, 8'h3C);
    chk("tx_o", o, 8'hA5);
    chk("tx_ovalid", {7'd0, o_valid}, 8'd0);
    I = 8'h5A;
    tick();
    chk("tx_io_lat", io_w, 8'h5A);
    T = 1;
    tick();
    chk("trx0_busy", {7'd0, busy}, 8'd1);
    chk("trx0_drive", {7'd0, drive}, 8'd0);
    chk("trx0_io", io_w, 8'hFF);
    T = 0;
    tick();
    chk("trx1_busy", {7'd0, busy}, 8'd1);
    chk("trx1_io", io_w, 8'hFF);
    T = 1; ext = 8'hC3; ext_en = 1;
    tick();
    chk("rx_busy", {7'd0, busy}, 8'd0);
    chk("rx_ovalid0", {7'd0, o_valid}, 8'd0);
    tick();
    chk("rx_o", o, 8'hC3);
    chk("rx_ovalid1", {7'd0, o_valid}, 8'd1);
    T = 0; ext_en = 0;
    tick();
    chk("abort_busy", {7'd0, busy}, 8'd1);
    chk("abort_io0", io_w, 8'hFF);
    T = 1;
    tick();
    chk("abort_rx_busy", {7'd0, busy}, 8'd0);
    chk("abort_drive", {7'd0, drive}, 8'd0);
    chk("abort_io1", io_w, 8'hFF);
    chk("abort_ovalid", {7'd0, o_valid}, 8'd0);
    tick();
    chk("abort_ovalid1", {7'd0, o_valid}, 8'd1);
    T = 0; I = 8'h96;
    tick();
    tick();
    tick();
    chk("gts_pre_drive", {7'd0, drive}, 8'd1);
    chk("gts_pre_io", io_w, 8'h96);
    #2 GTS = 1;
    #1;
    chk("gts_io", io_w, 8'hFF);
    chk("gts_drive", {7'd0, drive}, 8'd0);
    chk("gts_busy", {7'd0, busy}, 8'd0);
    tick();
    chk("gts_trx_busy", {7'd0, busy}, 8'd1);
    GTS = 0;
    tick();
    chk("gts_trx1_busy", {7'd0, busy}, 8'd1);
    chk("gts_trx1_io", io_w, 8'hFF);
    tick();
    chk("gts_rx_busy", {7'd0, busy}, 8'd0);
    chk("gts_rx_drive", {7'd0, drive}, 8'd0);
    tick();
    tick();
    tick();
    chk("clr_pre_drive", {7'd0, drive}, 8'd1);
    chk("clr_pre_io", io_w, 8'h96);
    chk("clr_pre_o", o, 8'hFF);
    #2 CLR_N = 0;
    #1;
    chk("clr_io", io_w, 8'hFF);
    chk("clr_drive", {7'd0, drive}, 8'd0);
    chk("clr_busy", {7'd0, busy}, 8'd0);
    chk("clr_o", o, 8'h00);
    chk("clr_ovalid", {7'd0, o_valid}, 8'd0);
    T = 1;
    #1 CLR_N = 1;
    tick();
    chk("clr_rx_ovalid", {7'd0, o_valid}, 8'd1);
    chk("clr_rx_busy", {7'd0, busy}, 8'd0);
    t0 = 0; i0 = 8'hE1;
    tick();
    chk("tc0_drive", {7'd0, drive0}, 8'd1);
    chk("tc0_busy", {7'd0, busy0}, 8'd0);
    chk("tc0_io", io0_w, 8'hE1);
    t0 = 1;
    tick();
    chk("tc0_rx_drive", {7'd0, drive0}, 8'd0);
    chk("tc0_rx_busy", {7'd0, busy0}, 8'd0);
    chk("tc0_rx_io", io0_w, 8'hFF);
    t0 = 0;
    tick();
    chk("tc0_tx2_io", io0_w, 8'hE1);
    #2 clr0_n = 0;
    #1;
    chk("tc0_clr_io", io0_w, 8'hFF);
    chk("tc0_clr_drive", {7'd0, drive0}, 8'd0);
    chk("tc0_clr_ovalid", {7'd0, o_valid0}, 8'd0);
    t0 = 1;
    #1 clr0_n = 1;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
